// File: rtl/stoplight_pkg.sv
// Shared definitions for the two-approach stoplight controller.
//   state_t      : 3-bit FSM state encoding (also visible on the State port)
//   lamps_t      : one bit per lamp, main approach, side approach, Walk
//   decode_lamps : Moore lamp decode from state and flash blink phase
package stoplight_pkg;

  typedef enum logic [2:0] {
    MAIN_GRN  = 3'd0,
    MAIN_YEL  = 3'd1,
    ALL_RED_A = 3'd2,
    SIDE_GRN  = 3'd3,
    SIDE_YEL  = 3'd4,
    ALL_RED_B = 3'd5,
    WALK      = 3'd6,
    FLASH     = 3'd7
  } state_t;

  typedef struct packed {
    logic main_g;
    logic main_y;
    logic main_r;
    logic side_g;
    logic side_y;
    logic side_r;
    logic walk;
  } lamps_t;

  // Each approach shows red unless its own green/yellow state is active.
  // FLASH is the exception: main blinks yellow, side blinks red, nothing else lit.
  function automatic lamps_t decode_lamps(input state_t s, input logic blink);
    lamps_t l;
    l        = '0;
    l.main_r = 1'b1;
    l.side_r = 1'b1;
    case (s)
      MAIN_GRN: begin l.main_r = 1'b0; l.main_g = 1'b1; end
      MAIN_YEL: begin l.main_r = 1'b0; l.main_y = 1'b1; end
      SIDE_GRN: begin l.side_r = 1'b0; l.side_g = 1'b1; end
      SIDE_YEL: begin l.side_r = 1'b0; l.side_y = 1'b1; end
      WALK:     l.walk = 1'b1;
      FLASH: begin
        l.main_r = 1'b0;
        l.main_y = blink;
        l.side_r = blink;
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/stoplight_timer.sv
// Loadable phase down-counter.
//   CLK      : clock, rising edge
//   Reset    : synchronous active-high; loads RST_VAL
//   load     : load load_val this edge (has priority over counting)
//   load_val : value to load (phase duration - 1)
//   value    : current count; decrements to 0 and holds there
//   expired  : value == 0
module stoplight_timer #(
  parameter int TW      = 8,
  parameter int RST_VAL = 0
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic [TW-1:0] value,
  output logic          expired
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always blocks execute in.
  always_ff @(posedge CLK) begin
    if (Reset)                value <= TW'(RST_VAL);
    else if (load)            value <= load_val;
    else if (value != '0)     value <= value - 1'b1;
  end

  assign expired = (value == '0);

endmodule

// File: rtl/stoplight_ctrl.sv
// Two-approach intersection controller with pedestrian phase and
// maintenance flash.
//   CLK                 : clock, all state changes on rising edge
//   Reset               : synchronous active-high reset
//   Ped                 : pedestrian button (level, latched into a request)
//   SideCar             : side-road vehicle sensor (level, latched)
//   Flash               : maintenance flash request, honoured only in all-red
//   MainG/MainY/MainR   : main-road lamps
//   SideG/SideY/SideR   : side-road lamps
//   Walk                : pedestrian Walk lamp
//   State               : current FSM state code
module stoplight_ctrl
  import stoplight_pkg::*;
#(
  parameter int MIN_GREEN = 8,
  parameter int SIDE_T    = 6,
  parameter int YEL_T     = 3,
  parameter int RED_T     = 2,
  parameter int WALK_T    = 5,
  parameter int FLASH_T   = 4,
  parameter int TW        = 8
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Ped,
  input  logic       SideCar,
  input  logic       Flash,
  output logic       MainG,
  output logic       MainY,
  output logic       MainR,
  output logic       SideG,
  output logic       SideY,
  output logic       SideR,
  output logic       Walk,
  output logic [2:0] State
);

  state_t          state_q, next_state;
  logic            ped_req_q, car_req_q, blink_q;
  logic            ped_pend, car_pend;
  logic            enter, enter_walk, enter_side, flash_reload;
  logic            timer_load, timer_expired;
  logic [TW-1:0]   timer_load_val, timer_value;
  logic            unused_timer_value;
  lamps_t          lamps;

  // Count to load on entry to a state so that it lasts exactly its duration.
  function automatic logic [TW-1:0] phase_load(input state_t s);
    case (s)
      MAIN_GRN:             return TW'(MIN_GREEN - 1);
      MAIN_YEL, SIDE_YEL:   return TW'(YEL_T - 1);
      SIDE_GRN:             return TW'(SIDE_T - 1);
      WALK:                 return TW'(WALK_T - 1);
      FLASH:                return TW'(FLASH_T - 1);
      default:              return TW'(RED_T - 1);
    endcase
  endfunction

  // A press counts in the same cycle it arrives, not only once latched.
  assign ped_pend = ped_req_q | Ped;
  assign car_pend = car_req_q | SideCar;

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state_q;
    case (state_q)
      MAIN_GRN:  if (timer_expired && (ped_pend || car_pend)) next_state = MAIN_YEL;
      MAIN_YEL:  if (timer_expired) next_state = ALL_RED_A;
      ALL_RED_A: if (timer_expired) begin
        if (Flash)         next_state = FLASH;
        else if (car_pend) next_state = SIDE_GRN;
        else               next_state = WALK;
      end
      SIDE_GRN:  if (timer_expired) next_state = SIDE_YEL;
      SIDE_YEL:  if (timer_expired) next_state = ALL_RED_B;
      ALL_RED_B: if (timer_expired) begin
        if (Flash)         next_state = FLASH;
        else if (ped_pend) next_state = WALK;
        else               next_state = MAIN_GRN;
      end
      WALK:      if (timer_expired) next_state = ALL_RED_B;
      FLASH:     if (!Flash) next_state = ALL_RED_B;
      default:   next_state = MAIN_GRN;
    endcase
  end

  assign enter      = (next_state != state_q);
  assign enter_walk = enter && (next_state == WALK);
  assign enter_side = enter && (next_state == SIDE_GRN);
  // FLASH has no exit timer; the timer only paces the blink half-period.
  assign flash_reload   = (state_q == FLASH) && (next_state == FLASH) && timer_expired;
  assign timer_load     = enter || flash_reload;
  assign timer_load_val = phase_load(next_state);

  stoplight_timer #(
    .TW      (TW),
    .RST_VAL (MIN_GREEN - 1)
  ) u_timer (
    .CLK      (CLK),
    .Reset    (Reset),
    .load     (timer_load),
    .load_val (timer_load_val),
    .value    (timer_value),
    .expired  (timer_expired)
  );

  // The raw count is a debug tap on the timer; only expiry steers the FSM.
  assign unused_timer_value = ^timer_value;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= MAIN_GRN;
      ped_req_q <= 1'b0;
      car_req_q <= 1'b0;
      blink_q   <= 1'b0;
    end else begin
      state_q   <= next_state;
      // Set wins over the clear on phase entry, so a press is never lost.
      ped_req_q <= Ped     | (ped_req_q & ~enter_walk);
      car_req_q <= SideCar | (car_req_q & ~enter_side);
      if (enter && (next_state == FLASH)) blink_q <= 1'b0;
      else if (flash_reload)              blink_q <= ~blink_q;
    end
  end

  assign lamps = decode_lamps(state_q, blink_q);
  assign MainG = lamps.main_g;
  assign MainY = lamps.main_y;
  assign MainR = lamps.main_r;
  assign SideG = lamps.side_g;
  assign SideY = lamps.side_y;
  assign SideR = lamps.side_r;
  assign Walk  = lamps.walk;
  assign State = state_q;

endmodule

// File: doc/stoplight_ctrl.md
Name: stoplight_ctrl

Overview:
Parametrised two-approach intersection controller, successor to the single-approach pedestrian stoplight. Drives main-road and side-road G/Y/R lamps plus a pedestrian Walk lamp from one timer-driven FSM. Phase durations are parameters; side-road car sensing and pedestrian requests are latched; a maintenance flash mode is added. Sits at the top of the stoplight design and is driven by the stoplight benches.

Parameters:
MIN_GREEN, 8, cycles main green is held before it may yield (>=1)
SIDE_T, 6, side green duration in cycles (>=1)
YEL_T, 3, yellow duration in cycles, both approaches (>=1)
RED_T, 2, all-red clearance duration in cycles (>=1)
WALK_T, 5, Walk duration in cycles (>=1)
FLASH_T, 4, half-period of flash blink in cycles (>=1)
TW, 8, timer width; must hold max(all durations)-1

Ports:
CLK  in  1  clock, all state changes on rising edge
Reset  in  1  synchronous, active-high reset
Ped  in  1  pedestrian button, level, sampled every edge
SideCar  in  1  side-road vehicle sensor, level
Flash  in  1  maintenance flash request, level
MainG, MainY, MainR  out  1 each  main-road lamps
SideG, SideY, SideR  out  1 each  side-road lamps
Walk  out  1  pedestrian Walk lamp
State  out  3  current FSM state code (debug/verification)

Behaviour:
- One clock, CLK. Reset is synchronous and active-high. While Reset=1 at an edge: State=MAIN_GRN, timer=MIN_GREEN-1, PedReq=0, CarReq=0, blink=0. Outputs MainG=1, SideR=1, all others 0.
- State codes: MAIN_GRN=0, MAIN_YEL=1, ALL_RED_A=2, SIDE_GRN=3, SIDE_YEL=4, ALL_RED_B=5, WALK=6, FLASH=7.
- Timer: on entry to a state, load duration-1. Decrement each cycle to 0 and hold. "Expired" means timer==0, so a timed state lasts exactly its duration in cycles.
- Latches: PedReq is set when Ped=1 and cleared on the cycle WALK is entered. CarReq is set when SideCar=1 and cleared on entry to SIDE_GRN. A Ped or SideCar press in the same cycle as the clear re-sets the latch, because set wins.
- Transitions (evaluated at expiry):
  - MAIN_GRN -> MAIN_YEL only if expired and (PedReq|CarReq). Otherwise it holds indefinitely.
  - MAIN_YEL -> ALL_RED_A.
  - ALL_RED_A -> FLASH if Flash; else SIDE_GRN if CarReq; else WALK.
  - SIDE_GRN -> SIDE_YEL.
  - SIDE_YEL -> ALL_RED_B.
  - ALL_RED_B -> FLASH if Flash; else WALK if PedReq; else MAIN_GRN.
  - WALK -> ALL_RED_B. PedReq is already clear, so ALL_RED_B then goes to MAIN_GRN unless Ped was pressed again.
  - FLASH -> ALL_RED_B when Flash=0 (no timer condition).
- Flash is honoured only in the all-red states. This guarantees the controller never goes straight from a green into flash.
- Lamp outputs are Moore, decoded from State:
  - Main lamps: G in MAIN_GRN, Y in MAIN_YEL, R otherwise.
  - Side lamps: G in SIDE_GRN, Y in SIDE_YEL, R otherwise.
  - Walk=1 only in WALK.
  - In FLASH: MainY=blink, SideR=blink, all other lamps 0. blink toggles on each timer expiry; the timer reloads FLASH_T-1 on each expiry; blink resets to 0 on FLASH entry.
- Invariant: MainG|MainY and SideG|SideY|Walk are never both 1. At most one lamp per approach is lit.
- Reset mid-phase aborts the phase immediately to the reset state next cycle.

Decomposition:
- Shared package stoplight_pkg: state encoding constants, the 3-bit state typedef, and the lamp-decode function. Benches use it for State comparisons.
- One sub-module: stoplight_timer, a TW-bit loadable down-counter with load/value/expired.

Test Plan:
- Reset, no inputs for 50 cycles -> State stays 0, MainG=1, SideR=1, Walk=0 throughout.
- SideCar=1 for one cycle at cycle 2 -> MAIN_GRN until cycle 8, MAIN_YEL cycles 8-10, ALL_RED_A 11-12, SIDE_GRN 13-18, SIDE_YEL 19-21, ALL_RED_B 22-23, MAIN_GRN at 24.
- Ped=1 at cycle 20 (MAIN_GRN held) -> MAIN_YEL at 21, ALL_RED_A 24-25, WALK 26-30 with Walk=1, ALL_RED_B 31-32, MAIN_GRN 33; PedReq=0 at cycle 26.
- Ped and SideCar both pressed during main green -> sequence SIDE_GRN, SIDE_YEL, ALL_RED_B, WALK, ALL_RED_B, MAIN_GRN; Walk never overlaps SideG.
- Flash=1 during SIDE_GRN -> no change until ALL_RED_B, then FLASH with MainY/SideR toggling every 4 cycles; drop Flash -> ALL_RED_B for 2 cycles -> MAIN_GRN.
- Reset=1 for one cycle while in WALK -> next cycle State=0, Walk=0, PedReq=0. Random Ped/SideCar for 100k cycles -> lamp invariant never violated, and every state 0-6 is reached.
